// File: rtl/expr_eval.sv
// Streaming single-digit expression evaluator: tracks syntax and computes the value with '*' precedence.
// Optional EXPR_EVAL_DIV_EN adds '/' as a signed, truncating mul-class operator.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             ok,
    output logic             err
);

    typedef enum logic [1:0] {START, NUM, OP, ERR} state_t;
    typedef enum logic [1:0] {P_ADD, P_SUB, P_MUL, P_DIV} pend_t;

    state_t           state, state_n;
    pend_t            pend, pend_n;
    logic [WIDTH-1:0] sum, sum_n;
    logic [WIDTH-1:0] term, term_n;

    logic             is_digit, is_add, is_sub, is_mul, is_div;
    logic [WIDTH-1:0] dval;

    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign is_add   = (in == 8'h2B);
    assign is_sub   = (in == 8'h2D);
    assign is_mul   = (in == 8'h2A);
`ifdef EXPR_EVAL_DIV_EN
    assign is_div   = (in == 8'h2F);
`else
    assign is_div   = 1'b0;
`endif
    // The low nibble of an ASCII digit is its value.
    assign dval = {{(WIDTH-4){1'b0}}, in[3:0]};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_n = state;
        pend_n  = pend;
        sum_n   = sum;
        term_n  = term;
        if (in_valid) begin
            case (state)
                START: begin
                    if (is_digit) begin
                        state_n = NUM;
                        term_n  = dval;
                    end else begin
                        state_n = ERR;
                    end
                end
                NUM: begin
                    if (is_add || is_sub) begin
                        state_n = OP;
                        sum_n   = sum + term;
                        pend_n  = is_sub ? P_SUB : P_ADD;
                    end else if (is_mul) begin
                        state_n = OP;
                        pend_n  = P_MUL;
                    end else if (is_div) begin
                        state_n = OP;
                        pend_n  = P_DIV;
                    end else begin
                        state_n = ERR;
                    end
                end
                OP: begin
                    if (is_digit) begin
                        state_n = NUM;
                        case (pend)
                            P_ADD: term_n = dval;
                            P_SUB: term_n = '0 - dval;
                            P_MUL: term_n = term * dval;
                            P_DIV: begin
`ifdef EXPR_EVAL_DIV_EN
                                if (in[3:0] == 4'd0) state_n = ERR;
                                else term_n = WIDTH'($signed(term) / $signed(dval));
`else
                                state_n = ERR;
`endif
                            end
                        endcase
                    end else begin
                        state_n = ERR;
                    end
                end
                ERR: state_n = ERR;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they track the state registers exactly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (clr) begin
            state  <= START;
            pend   <= P_ADD;
            sum    <= '0;
            term   <= '0;
            ok     <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            sum    <= sum_n;
            term   <= term_n;
            ok     <= (state_n == NUM);
            err    <= (state_n == ERR);
            result <= (state_n == NUM) ? (sum_n + term_n) : '0;
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Randomized bench for expr_eval: a string-level reference model re-parses the accepted characters each cycle.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in = 8'h00;
    logic        in_valid = 1'b0;
    logic [15:0] result;
    logic        ok, err;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    logic [7:0] q[$];

    expr_eval #(.WIDTH(16)) dut (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .result(result), .ok(ok), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: evaluate the whole accepted string with exact integer math, truncated at the end.
    function automatic void model_eval(output bit mok, output bit merr, output logic [15:0] mres);
        longint sum, term;
        int d;
        logic [7:0] c;
        sum = 0; term = 0;
        mok = 0; merr = 0; mres = 16'h0;
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            if (i % 2 == 0) begin
                if (!(c >= 8'h30 && c <= 8'h39)) begin merr = 1; return; end
                d = int'(c) - 48;
                if (i == 0) term = d;
                else if (q[i-1] == 8'h2B) term = d;
                else if (q[i-1] == 8'h2D) term = -d;
                else if (q[i-1] == 8'h2A) term = term * d;
                else begin
                    if (d == 0) begin merr = 1; return; end
                    term = longint'(shortint'(term[15:0])) / d;
                end
            end else begin
                if (c == 8'h2B || c == 8'h2D) sum = sum + term;
                else if (c == 8'h2A) ;
`ifdef EXPR_EVAL_DIV_EN
                else if (c == 8'h2F) ;
`endif
                else begin merr = 1; return; end
            end
        end
        if (q.size() % 2 == 1) begin
            mok  = 1;
            mres = 16'(sum + term);
        end
    endfunction

    always @(posedge clk) begin
        if (clr) q.delete();
        else if (in_valid) q.push_back(in);
    end

    always @(negedge clk) begin
        bit mok, merr;
        logic [15:0] mres;
        if (checking) begin
            model_eval(mok, merr, mres);
            check("ok", 32'(ok), 32'(mok));
            check("err", 32'(err), 32'(merr));
            check("result", 32'(result), 32'(mres));
        end
    end

    task automatic drive(input logic c_clr, input logic v, input logic [7:0] ch);
        clr = c_clr; in_valid = v; in = ch;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i]);
    endtask

    task automatic lit(input string name, input logic eok, input logic eerr, input logic [15:0] eres);
        check({name, ".ok"}, 32'(ok), 32'(eok));
        check({name, ".err"}, 32'(err), 32'(eerr));
        check({name, ".result"}, 32'(result), 32'(eres));
    endtask

    initial begin
        logic [7:0] ops[4];
        logic [7:0] ch;
        int r;
        bit want_digit;
        ops = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};

        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00);
        checking = 1'b1;
        lit("reset", 1'b0, 1'b0, 16'h0000);

        feed("1+");
        lit("1+", 1'b0, 1'b0, 16'h0000);
        feed("2*3");
        lit("1+2*3", 1'b1, 1'b0, 16'd7);

        drive(1'b1, 1'b0, 8'h00);
        feed("9-4-8");
        lit("9-4-8", 1'b1, 1'b0, 16'hFFFD);

        drive(1'b1, 1'b0, 8'h00);
        feed("2");
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h37);
        lit("idle2", 1'b1, 1'b0, 16'd2);
        feed("*");
        drive(1'b0, 1'b0, 8'h35);
        lit("idle*", 1'b0, 1'b0, 16'd0);
        feed("9");
        lit("2*9", 1'b1, 1'b0, 16'd18);

        drive(1'b1, 1'b0, 8'h00);
        feed("+");
        lit("+", 1'b0, 1'b1, 16'd0);
        feed("12");
        lit("err_sticky", 1'b0, 1'b1, 16'd0);
        drive(1'b1, 1'b1, 8'h35);
        lit("clr_wins", 1'b0, 1'b0, 16'd0);

        feed("9*9*9*9*9*9");
        lit("9^6", 1'b1, 1'b0, 16'h1BF1);
        drive(1'b1, 1'b0, 8'h00);
        feed("12");
        lit("12", 1'b0, 1'b1, 16'd0);
        drive(1'b1, 1'b0, 8'h00);
        feed("3a");
        lit("3a", 1'b0, 1'b1, 16'd0);

`ifdef EXPR_EVAL_DIV_EN
        drive(1'b1, 1'b0, 8'h00);
        feed("7/2*3");
        lit("7/2*3", 1'b1, 1'b0, 16'd9);
        drive(1'b1, 1'b0, 8'h00);
        feed("0-7/2");
        lit("0-7/2", 1'b1, 1'b0, 16'hFFFD);
        drive(1'b1, 1'b0, 8'h00);
        feed("8/0");
        lit("8/0", 1'b0, 1'b1, 16'd0);
`else
        drive(1'b1, 1'b0, 8'h00);
        feed("8/");
        lit("8/", 1'b0, 1'b1, 16'd0);
`endif

        // Random traffic, biased toward well-formed expressions so long chains build up.
        drive(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(99);
            want_digit = (q.size() % 2 == 0);
            if ($urandom_range(11) == 0) want_digit = !want_digit;
            if ($urandom_range(39) == 0) ch = 8'($urandom_range(255));
            else if (want_digit) ch = 8'h30 + 8'($urandom_range(9));
            else ch = ops[$urandom_range(3)];
            if (r < 3 || (q.size() > 14 && r < 30) || (err && r < 25))
                drive(1'b1, 1'($urandom_range(1)), ch);
            else if (r < 15)
                drive(1'b0, 1'b0, ch);
            else
                drive(1'b0, 1'b1, ch);
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
